// File: rtl/med_alarm_if.sv
// Bundle of stimulus, alarm and log-record signals between the medication
// scheduler front end and the alarm sequencer.
interface med_alarm_if;
  logic [7:0] due_vec;
  logic       tick;
  logic       ack;
  logic       log_ready;
  logic [1:0] alarm_level;
  logic [2:0] cur_slot;
  logic [7:0] pending;
  logic       log_valid;
  logic [2:0] log_slot;
  logic       log_taken;
  logic       overrun;

  modport master (
    output due_vec, tick, ack, log_ready,
    input  alarm_level, cur_slot, pending, log_valid, log_slot, log_taken, overrun
  );
  modport slave (
    input  due_vec, tick, ack, log_ready,
    output alarm_level, cur_slot, pending, log_valid, log_slot, log_taken, overrun
  );
endinterface

// File: rtl/med_alarm_sequencer.sv
// Serves due medication slots one at a time: alert, escalate on timeout,
// and emit one log record (taken/missed) per served dose.
module med_alarm_sequencer #(
  parameter int unsigned ACK_TICKS = 10,
  parameter int unsigned ESC_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  med_alarm_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ALERT    = 2'd1;
  localparam logic [1:0] ESCALATE = 2'd2;
  localparam logic [1:0] LOG      = 2'd3;
  localparam logic [7:0] ACK_LAST = 8'(ACK_TICKS - 1);
  localparam logic [7:0] ESC_LAST = 8'(ESC_TICKS - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       ack_prev;
  logic [2:0] last_served;
  logic       ack_rise;
  logic       gnt_ok;
  logic [2:0] gnt;
  logic [2:0] idx;
  logic [7:0] clr;

  assign ack_rise = bus.ack & ~ack_prev;

  // Round-robin search starting just after the last served slot.
  always_comb begin
    gnt_ok = 1'b0;
    gnt    = '0;
    idx    = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_served + 3'(k);
      if (!gnt_ok && bus.pending[idx]) begin
        gnt_ok = 1'b1;
        gnt    = idx;
      end
    end
    clr = (state == IDLE && gnt_ok) ? (8'd1 << gnt) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ack_prev        <= 1'b0;
      last_served     <= 3'd7;
      bus.alarm_level <= 2'd0;
      bus.cur_slot    <= '0;
      bus.pending     <= '0;
      bus.log_valid   <= 1'b0;
      bus.log_slot    <= '0;
      bus.log_taken   <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      ack_prev <= bus.ack;
      // A due pulse on the slot being granted is a fresh dose, not an overrun.
      bus.pending <= (bus.pending & ~clr) | bus.due_vec;
      if (|(bus.due_vec & bus.pending & ~clr)) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (gnt_ok) begin
          state           <= ALERT;
          bus.alarm_level <= 2'd1;
          bus.cur_slot    <= gnt;
          last_served     <= gnt;
          cnt             <= '0;
        end
        ALERT: begin
          if (ack_rise) begin
            state           <= LOG;
            bus.alarm_level <= 2'd0;
            bus.log_valid   <= 1'b1;
            bus.log_slot    <= bus.cur_slot;
            bus.log_taken   <= 1'b1;
          end else if (bus.tick) begin
            if (cnt == ACK_LAST) begin
              state           <= ESCALATE;
              bus.alarm_level <= 2'd2;
              cnt             <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ESCALATE: begin
          if (ack_rise) begin
            state           <= LOG;
            bus.alarm_level <= 2'd0;
            bus.log_valid   <= 1'b1;
            bus.log_slot    <= bus.cur_slot;
            bus.log_taken   <= 1'b1;
          end else if (bus.tick) begin
            if (cnt == ESC_LAST) begin
              state           <= LOG;
              bus.alarm_level <= 2'd0;
              bus.log_valid   <= 1'b1;
              bus.log_slot    <= bus.cur_slot;
              bus.log_taken   <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: if (bus.log_ready) begin
          bus.log_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_med_alarm_sequencer.sv
// Directed scenarios plus randomized traffic checked against a dose-level model.
module tb_med_alarm_sequencer;
  localparam int ACK = 10;
  localparam int ESC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;

  med_alarm_if bus();

  med_alarm_sequencer #(.ACK_TICKS(ACK), .ESC_TICKS(ESC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: a dose is either absent (0), sounding (1) or being logged (2);
  // alarm level follows from ticks elapsed since the grant.
  int m_busy, m_slot, m_ticks, m_last;
  bit m_taken, m_ovr, m_ackp;
  bit [7:0] m_pend;

  function automatic void model_reset();
    m_busy = 0; m_slot = 0; m_ticks = 0; m_last = 7;
    m_taken = 0; m_ovr = 0; m_ackp = 0; m_pend = 0;
  endfunction

  function automatic void model_step(input bit [7:0] d, input bit t, input bit a, input bit r);
    bit [7:0] clr;
    bit found;
    int s;
    clr = 0;
    found = 0;
    if (m_busy == 0) begin
      for (int k = 1; k <= 8; k++) begin
        s = (m_last + k) % 8;
        if (!found && m_pend[s]) begin found = 1; m_slot = s; end
      end
      if (found) begin
        clr[m_slot] = 1'b1; m_last = m_slot; m_busy = 1; m_ticks = 0;
      end
    end else if (m_busy == 1) begin
      if (a && !m_ackp) begin
        m_busy = 2; m_taken = 1;
      end else if (t) begin
        m_ticks++;
        if (m_ticks == ACK + ESC) begin m_busy = 2; m_taken = 0; end
      end
    end else if (r) begin
      m_busy = 0;
    end
    if ((d & m_pend & ~clr) != 0) m_ovr = 1;
    m_pend = (m_pend & ~clr) | d;
    m_ackp = a;
  endfunction

  task automatic cyc(input logic [7:0] d, input logic t, input logic a, input logic r);
    bus.due_vec = d; bus.tick = t; bus.ack = a; bus.log_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.due_vec = 0; bus.tick = 0; bus.ack = 0; bus.log_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.alarm_level !== 2'd0) $display("FAIL reset_level got %0d exp 0", bus.alarm_level); else passed++;
    total++; if (bus.pending !== 8'h00) $display("FAIL reset_pending got %h exp 00", bus.pending); else passed++;
    total++; if ({bus.log_valid, bus.log_slot, bus.log_taken, bus.overrun, bus.cur_slot} !== 9'd0)
      $display("FAIL reset_fields got %b exp 0", {bus.log_valid, bus.log_slot, bus.log_taken, bus.overrun, bus.cur_slot}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_ack_basic();
    do_reset();
    cyc(8'h04, 0, 0, 0);
    total++; if (bus.alarm_level !== 2'd0) $display("FAIL ack_latency1 got %0d exp 0", bus.alarm_level); else passed++;
    cyc(8'h00, 0, 0, 0);
    total++; if (bus.alarm_level !== 2'd1) $display("FAIL ack_alert got %0d exp 1", bus.alarm_level); else passed++;
    total++; if (bus.cur_slot !== 3'd2) $display("FAIL ack_slot got %0d exp 2", bus.cur_slot); else passed++;
    total++; if (bus.pending !== 8'h00) $display("FAIL ack_pend got %h exp 00", bus.pending); else passed++;
    cyc(8'h00, 0, 0, 0);
    cyc(8'h00, 0, 1, 0);
    total++; if ({bus.log_valid, bus.log_slot, bus.log_taken, bus.alarm_level} !== {1'b1, 3'd2, 1'b1, 2'd0})
      $display("FAIL ack_log got %b exp 1_010_1_00", {bus.log_valid, bus.log_slot, bus.log_taken, bus.alarm_level}); else passed++;
    cyc(8'h00, 0, 1, 1);
    cyc(8'h00, 0, 0, 0);
    total++; if ({bus.log_valid, bus.alarm_level} !== 3'd0) $display("FAIL ack_idle got %b exp 000", {bus.log_valid, bus.alarm_level}); else passed++;
  endtask

  task automatic test_escalate_miss();
    do_reset();
    cyc(8'h01, 0, 0, 1);
    cyc(8'h00, 0, 0, 1);
    for (int i = 1; i <= 15; i++) begin
      cyc(8'h00, 1, 0, 1);
      if (i == 9) begin
        total++; if (bus.alarm_level !== 2'd1) $display("FAIL esc_tick9 got %0d exp 1", bus.alarm_level); else passed++;
      end
      if (i == 10 || i == 14) begin
        total++; if ({bus.alarm_level, bus.log_valid} !== 3'b100) $display("FAIL esc_tick%0d got %b exp 100", i, {bus.alarm_level, bus.log_valid}); else passed++;
      end
    end
    total++; if ({bus.log_valid, bus.log_slot, bus.log_taken, bus.alarm_level} !== {1'b1, 3'd0, 1'b0, 2'd0})
      $display("FAIL esc_missed got %b exp 1_000_0_00", {bus.log_valid, bus.log_slot, bus.log_taken, bus.alarm_level}); else passed++;
    cyc(8'h00, 0, 0, 1);
    total++; if (bus.log_valid !== 1'b0) $display("FAIL esc_release got %b exp 0", bus.log_valid); else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    cyc(8'h81, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    total++; if ({bus.cur_slot, bus.pending} !== {3'd0, 8'h80}) $display("FAIL rr_first got %0d/%h exp 0/80", bus.cur_slot, bus.pending); else passed++;
    cyc(8'h00, 0, 1, 0);
    cyc(8'h00, 0, 1, 1);
    cyc(8'h00, 0, 0, 0);
    total++; if ({bus.alarm_level, bus.cur_slot} !== {2'd1, 3'd7}) $display("FAIL rr_second got %0d/%0d exp 1/7", bus.alarm_level, bus.cur_slot); else passed++;
    cyc(8'h09, 0, 1, 0);
    cyc(8'h00, 0, 0, 1);
    cyc(8'h00, 0, 0, 0);
    total++; if (bus.cur_slot !== 3'd0) $display("FAIL rr_wrap got %0d exp 0", bus.cur_slot); else passed++;
    cyc(8'h00, 0, 1, 0);
    cyc(8'h00, 0, 0, 1);
    cyc(8'h00, 0, 0, 0);
    total++; if ({bus.cur_slot, bus.pending} !== {3'd3, 8'h00}) $display("FAIL rr_next got %0d/%h exp 3/00", bus.cur_slot, bus.pending); else passed++;
  endtask

  task automatic test_ack_tick_tie();
    do_reset();
    cyc(8'h20, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(8'h00, 1, 0, 0);
    total++; if (bus.alarm_level !== 2'd1) $display("FAIL tie_pre got %0d exp 1", bus.alarm_level); else passed++;
    cyc(8'h00, 1, 1, 0);
    total++; if ({bus.alarm_level, bus.log_valid, bus.log_taken} !== 4'b0011) $display("FAIL tie_taken got %b exp 0011", {bus.alarm_level, bus.log_valid, bus.log_taken}); else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1, 0, 0);
      total++; if ({bus.log_valid, bus.log_slot, bus.log_taken} !== {1'b1, 3'd5, 1'b1})
        $display("FAIL tie_hold%0d got %b exp 1_101_1", i, {bus.log_valid, bus.log_slot, bus.log_taken}); else passed++;
    end
    cyc(8'h00, 0, 0, 1);
    total++; if (bus.log_valid !== 1'b0) $display("FAIL tie_release got %b exp 0", bus.log_valid); else passed++;
  endtask

  task automatic test_overrun_and_reset();
    do_reset();
    cyc(8'h04, 0, 0, 0);
    cyc(8'h04, 0, 0, 0);
    total++; if ({bus.cur_slot, bus.pending, bus.overrun} !== {3'd2, 8'h04, 1'b0})
      $display("FAIL same_cycle_due got %0d/%h/%b exp 2/04/0", bus.cur_slot, bus.pending, bus.overrun); else passed++;
    do_reset();
    cyc(8'h01, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    cyc(8'h02, 0, 0, 0);
    total++; if ({bus.pending, bus.overrun} !== {8'h02, 1'b0}) $display("FAIL ovr_first got %h/%b exp 02/0", bus.pending, bus.overrun); else passed++;
    cyc(8'h02, 0, 0, 0);
    total++; if ({bus.pending, bus.overrun} !== {8'h02, 1'b1}) $display("FAIL ovr_second got %h/%b exp 02/1", bus.pending, bus.overrun); else passed++;
    for (int i = 0; i < 10; i++) cyc(8'h00, 1, 0, 0);
    total++; if (bus.alarm_level !== 2'd2) $display("FAIL ovr_escalate got %0d exp 2", bus.alarm_level); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.alarm_level, bus.cur_slot, bus.pending} !== 13'd0) $display("FAIL async_rst_a got %b exp 0", {bus.alarm_level, bus.cur_slot, bus.pending}); else passed++;
    total++; if ({bus.log_valid, bus.log_slot, bus.log_taken, bus.overrun} !== 6'd0) $display("FAIL async_rst_b got %b exp 0", {bus.log_valid, bus.log_slot, bus.log_taken, bus.overrun}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1, 1, 1);
      total++; if ({bus.log_valid, bus.alarm_level} !== 3'd0) $display("FAIL post_rst%0d got %b exp 000", i, {bus.log_valid, bus.alarm_level}); else passed++;
    end
  endtask

  task automatic test_random();
    bit [7:0] d;
    bit t, a, r;
    int lvl;
    a = 0;
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      lvl = (m_busy == 1) ? ((m_ticks < ACK) ? 1 : 2) : 0;
      total++; if (bus.alarm_level !== 2'(lvl)) $display("FAIL rand_level c%0d got %0d exp %0d", i, bus.alarm_level, lvl); else passed++;
      total++; if (bus.pending !== m_pend) $display("FAIL rand_pending c%0d got %h exp %h", i, bus.pending, m_pend); else passed++;
      total++; if (bus.overrun !== m_ovr) $display("FAIL rand_overrun c%0d got %b exp %b", i, bus.overrun, m_ovr); else passed++;
      total++; if (bus.log_valid !== (m_busy == 2)) $display("FAIL rand_log_valid c%0d got %b exp %b", i, bus.log_valid, m_busy == 2); else passed++;
      if (m_busy != 0) begin
        total++; if (bus.cur_slot !== 3'(m_slot)) $display("FAIL rand_cur_slot c%0d got %0d exp %0d", i, bus.cur_slot, m_slot); else passed++;
      end
      if (m_busy == 2) begin
        total++; if ({bus.log_slot, bus.log_taken} !== {3'(m_slot), m_taken})
          $display("FAIL rand_log_rec c%0d got %0d/%b exp %0d/%b", i, bus.log_slot, bus.log_taken, m_slot, m_taken); else passed++;
      end
      d = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) a = ~a;
      r = 1'($urandom_range(0, 1));
      model_step(d, t, a, r);
      cyc(d, t, a, r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.due_vec = 0; bus.tick = 0; bus.ack = 0; bus.log_ready = 0;
    test_reset();
    test_ack_basic();
    test_escalate_miss();
    test_round_robin();
    test_ack_tick_tie();
    test_overrun_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
